pipe_scroll_ctrl: RTL and testbench

PIPE_SCROLL_CTRL -- requirements
Module: pipe_scroll_ctrl

---
 rtl/pipe_scroll_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_scroll_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroll_ctrl.sv
// Scrolls two pipe pairs across the screen, respawns them with LFSR heights and keeps score.
// Latency: every output is registered, one cycle after the qualifying input edge.
// Backpressure: none; game_tick is a one-cycle enable and is never stalled.
module pipe_scroll_ctrl #(
    parameter int SCREEN_W = 640,
    parameter int PIPE_W   = 41,
    parameter int SPACING  = 320,
    parameter int BIRD_X   = 200,
    parameter int MIN_TOP  = 40
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       game_tick,
    input  logic       start,
    input  logic       collide,
    output logic [9:0] pipe1_l,
    output logic [9:0] pipe1_r,
    output logic [9:0] pipe1_high_b,
    output logic [9:0] pipe2_l,
    output logic [9:0] pipe2_r,
    output logic [9:0] pipe2_high_b,
    output logic [9:0] score,
    output logic       score_pulse,
    output logic       running,
    output logic       dead
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [9:0]  RESPAWN_X = 10'(SCREEN_W);
    localparam logic [9:0]  P2_INIT_X = 10'(SCREEN_W + SPACING);
    localparam logic [9:0]  R_OFS     = 10'(PIPE_W - 1);
    localparam logic [9:0]  BIRD_COL  = 10'(BIRD_X);
    localparam logic [9:0]  TOP       = 10'(MIN_TOP);
    localparam logic [9:0]  H1_INIT   = TOP + {2'b00, LFSR_SEED[7:0]};
    localparam logic [9:0]  H2_INIT   = TOP + {2'b00, LFSR_SEED[15:8]};
    localparam logic [9:0]  SCORE_MAX = 10'd999;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        move, reload, hit1, hit2;
    logic [9:0]  p1_l_d, p2_l_d, h1_d, h2_d, score_d;
    logic [10:0] score_sum;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)   state_d = S_RUN;
            S_RUN:   if (collide) state_d = S_DEAD;
            S_DEAD:  if (start)   state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // collide outranks game_tick: a colliding tick neither moves nor scores
        move   = (state_q == S_RUN) && game_tick && !collide;
        reload = (state_q == S_DEAD) && start;
        hit1   = move && (pipe1_r == BIRD_COL);
        hit2   = move && (pipe2_r == BIRD_COL);
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        p1_l_d = pipe1_l;
        p2_l_d = pipe2_l;
        h1_d   = pipe1_high_b;
        h2_d   = pipe2_high_b;
        if (reload) begin
            p1_l_d = RESPAWN_X;
            p2_l_d = P2_INIT_X;
            h1_d   = H1_INIT;
            h2_d   = H2_INIT;
        end else if (move) begin
            if (pipe1_l == '0) begin
                p1_l_d = RESPAWN_X;
                h1_d   = TOP + {2'b00, lfsr_q[7:0]};
            end else begin
                p1_l_d = pipe1_l - 10'd1;
            end
            if (pipe2_l == '0) begin
                p2_l_d = RESPAWN_X;
                h2_d   = TOP + {2'b00, lfsr_q[15:8]};
            end else begin
                p2_l_d = pipe2_l - 10'd1;
            end
        end

        score_sum = {1'b0, score} + {10'd0, hit1} + {10'd0, hit2};
        score_d   = score;
        if ((state_q == S_IDLE) && start) begin
            score_d = '0;
        end else if (move) begin
            score_d = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];
        end
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            pipe1_l      <= RESPAWN_X;
            pipe1_r      <= RESPAWN_X + R_OFS;
            pipe2_l      <= P2_INIT_X;
            pipe2_r      <= P2_INIT_X + R_OFS;
            pipe1_high_b <= H1_INIT;
            pipe2_high_b <= H2_INIT;
            score        <= '0;
            score_pulse  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            pipe1_l      <= p1_l_d;
            pipe1_r      <= p1_l_d + R_OFS;
            pipe2_l      <= p2_l_d;
            pipe2_r      <= p2_l_d + R_OFS;
            pipe1_high_b <= h1_d;
            pipe2_high_b <= h2_d;
            score        <= score_d;
            score_pulse  <= hit1 | hit2;
        end
    end

    assign running = (state_q == S_RUN);
    assign dead    = (state_q == S_DEAD);

endmodule

// File: tb/tb_pipe_scroll_ctrl.sv
// Bench for pipe_scroll_ctrl: instance 0 uses default geometry, instance 1 a tiny screen where
// both pairs overlap so double scoring, simultaneous respawn and score saturation are reachable.
module tb_pipe_scroll_ctrl;

    logic system_clk = 1'b0;
    logic reset = 1'b0, game_tick = 1'b0, start = 1'b0, collide = 1'b0;

    logic [9:0] o_p1l[2], o_p1r[2], o_h1[2], o_p2l[2], o_p2r[2], o_h2[2], o_sc[2];
    logic       o_pl[2], o_run[2], o_dead[2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 system_clk = ~system_clk;

    pipe_scroll_ctrl dut_a (
        .system_clk(system_clk), .reset(reset), .game_tick(game_tick), .start(start), .collide(collide),
        .pipe1_l(o_p1l[0]), .pipe1_r(o_p1r[0]), .pipe1_high_b(o_h1[0]),
        .pipe2_l(o_p2l[0]), .pipe2_r(o_p2r[0]), .pipe2_high_b(o_h2[0]),
        .score(o_sc[0]), .score_pulse(o_pl[0]), .running(o_run[0]), .dead(o_dead[0])
    );

    pipe_scroll_ctrl #(.SCREEN_W(20), .PIPE_W(5), .SPACING(0), .BIRD_X(10), .MIN_TOP(40)) dut_b (
        .system_clk(system_clk), .reset(reset), .game_tick(game_tick), .start(start), .collide(collide),
        .pipe1_l(o_p1l[1]), .pipe1_r(o_p1r[1]), .pipe1_high_b(o_h1[1]),
        .pipe2_l(o_p2l[1]), .pipe2_r(o_p2r[1]), .pipe2_high_b(o_h2[1]),
        .score(o_sc[1]), .score_pulse(o_pl[1]), .running(o_run[1]), .dead(o_dead[1])
    );

    // Reference model: 0 = idle, 1 = run, 2 = dead
    int m_st[2], m_l1[2], m_l2[2], m_h1[2], m_h2[2], m_sc[2], m_pl[2], m_lfsr[2];

    function automatic int p_sw(int k); return (k == 0) ? 640 : 20; endfunction
    function automatic int p_pw(int k); return (k == 0) ? 41 : 5; endfunction
    function automatic int p_sp(int k); return (k == 0) ? 320 : 0; endfunction
    function automatic int p_bx(int k); return (k == 0) ? 200 : 10; endfunction

    function automatic int nxt_lfsr(int v);
        int b;
        b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return (v >> 1) | (b << 15);
    endfunction

    function automatic int right_of(int k, int l);
        return (l + p_pw(k) - 1) % 1024;
    endfunction

    task automatic model_home(int k);
        m_l1[k] = p_sw(k);
        m_l2[k] = p_sw(k) + p_sp(k);
        m_h1[k] = 40 + ('hACE1 % 256);
        m_h2[k] = 40 + ('hACE1 / 256);
    endtask

    task automatic model_step(int k, bit r, bit s, bit t, bit c);
        int hits;
        if (r) begin
            m_st[k] = 0; m_sc[k] = 0; m_pl[k] = 0; m_lfsr[k] = 'hACE1;
            model_home(k);
        end else begin
            hits = 0;
            if (m_st[k] == 1 && t && !c) begin
                if (right_of(k, m_l1[k]) == p_bx(k)) hits++;
                if (right_of(k, m_l2[k]) == p_bx(k)) hits++;
                if (m_l1[k] == 0) begin m_l1[k] = p_sw(k); m_h1[k] = 40 + m_lfsr[k] % 256; end
                else m_l1[k]--;
                if (m_l2[k] == 0) begin m_l2[k] = p_sw(k); m_h2[k] = 40 + m_lfsr[k] / 256; end
                else m_l2[k]--;
                m_sc[k] = (m_sc[k] + hits > 999) ? 999 : m_sc[k] + hits;
            end
            m_pl[k] = (hits > 0) ? 1 : 0;
            if (m_st[k] == 0 && s) begin
                m_st[k] = 1; m_sc[k] = 0;
            end else if (m_st[k] == 1 && c) begin
                m_st[k] = 2;
            end else if (m_st[k] == 2 && s) begin
                m_st[k] = 0; model_home(k);
            end
            m_lfsr[k] = nxt_lfsr(m_lfsr[k]);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_model(int k);
        string p;
        p = (k == 0) ? "a." : "b.";
        chk({p, "p1l"},  o_p1l[k], m_l1[k]);
        chk({p, "p1r"},  o_p1r[k], right_of(k, m_l1[k]));
        chk({p, "h1"},   o_h1[k],  m_h1[k]);
        chk({p, "p2l"},  o_p2l[k], m_l2[k]);
        chk({p, "p2r"},  o_p2r[k], right_of(k, m_l2[k]));
        chk({p, "h2"},   o_h2[k],  m_h2[k]);
        chk({p, "score"}, o_sc[k], m_sc[k]);
        chk({p, "pulse"}, o_pl[k], m_pl[k]);
        chk({p, "running"}, o_run[k], (m_st[k] == 1) ? 1 : 0);
        chk({p, "dead"}, o_dead[k], (m_st[k] == 2) ? 1 : 0);
    endtask

    task automatic cyc(input bit r, input bit s, input bit t, input bit c);
        @(negedge system_clk);
        reset = r; start = s; game_tick = t; collide = c;
        for (int k = 0; k < 2; k++) model_step(k, r, s, t, c);
        @(posedge system_clk);
        #1;
        for (int k = 0; k < 2; k++) check_model(k);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".p1l"}, o_p1l[0], 640);  chk({tag, ".p1r"}, o_p1r[0], 680);
        chk({tag, ".p2l"}, o_p2l[0], 960);  chk({tag, ".p2r"}, o_p2r[0], 1000);
        chk({tag, ".h1"},  o_h1[0], 265);   chk({tag, ".h2"},  o_h2[0], 212);
        chk({tag, ".score"}, o_sc[0], 0);   chk({tag, ".pulse"}, o_pl[0], 0);
        chk({tag, ".running"}, o_run[0], 0); chk({tag, ".dead"}, o_dead[0], 0);
    endtask

    typedef struct {
        bit rst, st, tk, co;
        int e_run, e_dead, e_p1l, e_score, e_pulse;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n, pre_lfsr;
        bit r, s, t, c;

        tbl[0]  = '{1, 0, 0, 0, 0, 0, 640, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0, 0, 640, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 0, 640, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 1, 0, 640, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 1, 0, 639, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 1, 0, 638, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 1, 0, 638, 0, 0};
        tbl[7]  = '{0, 0, 1, 1, 0, 1, 638, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 0, 1, 638, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 640, 0, 0};
        tbl[10] = '{0, 1, 1, 0, 1, 0, 640, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 0, 1, 640, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 0, 640, 0, 0};

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].rst, tbl[i].st, tbl[i].tk, tbl[i].co);
            chk($sformatf("tbl%0d.running", i), o_run[0],  tbl[i].e_run);
            chk($sformatf("tbl%0d.dead", i),    o_dead[0], tbl[i].e_dead);
            chk($sformatf("tbl%0d.p1l", i),     o_p1l[0],  tbl[i].e_p1l);
            chk($sformatf("tbl%0d.score", i),   o_sc[0],   tbl[i].e_score);
            chk($sformatf("tbl%0d.pulse", i),   o_pl[0],   tbl[i].e_pulse);
        end

        // Idle after reset: ticks and collisions are inert
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 100; i++) cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check_reset_values("idle100");

        cyc(0, 1, 0, 0);
        repeat (10) cyc(0, 0, 1, 0);
        chk("run10.running", o_run[0], 1);
        chk("run10.p1l", o_p1l[0], 630);
        chk("run10.p1r", o_p1r[0], 670);
        chk("run10.p2l", o_p2l[0], 950);

        n = 0;
        while (o_p1r[0] != 200 && n < 1000) begin cyc(0, 0, 1, 0); n++; end
        chk("reach_r200", o_p1r[0], 200);
        chk("pre_pass.score", o_sc[0], 0);
        cyc(0, 0, 1, 0);
        chk("pass.pulse", o_pl[0], 1);
        chk("pass.score", o_sc[0], 1);
        cyc(0, 0, 0, 0);
        chk("pass_after.pulse", o_pl[0], 0);
        chk("pass_after.score", o_sc[0], 1);

        n = 0;
        while (o_p1l[0] != 0 && n < 1000) begin cyc(0, 0, 1, 0); n++; end
        chk("reach_l0", o_p1l[0], 0);
        pre_lfsr = m_lfsr[0];
        cyc(0, 0, 1, 0);
        chk("respawn.p1l", o_p1l[0], 640);
        chk("respawn.h1", o_h1[0], 40 + (pre_lfsr % 256));
        chk("respawn.h1_range", (o_h1[0] >= 40 && o_h1[0] <= 295) ? 1 : 0, 1);
        chk("respawn.p2l", o_p2l[0], 319);

        cyc(0, 0, 1, 1);
        chk("crash.p1l", o_p1l[0], 640);
        chk("crash.p2l", o_p2l[0], 319);
        chk("crash.dead", o_dead[0], 1);
        chk("crash.running", o_run[0], 0);
        cyc(0, 1, 0, 0);
        chk("back_idle.dead", o_dead[0], 0);
        chk("back_idle.p2l", o_p2l[0], 960);
        chk("back_idle.h1", o_h1[0], 265);
        chk("back_idle.score", o_sc[0], 1);
        cyc(0, 1, 0, 0);
        chk("restart.running", o_run[0], 1);
        chk("restart.score", o_sc[0], 0);

        n = 0;
        while (o_p1l[0] != 300 && n < 1000) begin cyc(0, 0, 1, 0); n++; end
        chk("reach_l300", o_p1l[0], 300);
        cyc(1, 1, 1, 1);
        check_reset_values("midrun_rst");

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 19) == 0);
            t = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 99) == 0);
            cyc(r, s, t, c);
        end

        // Long uninterrupted run drives the small instance into saturation
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (10600) cyc(0, 0, 1, 0);
        chk("b.saturated", o_sc[1], 999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
